// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants and the zigzag-to-natural scan table used by
// both the encoder zigzag stage and the RLE block decoder.
package jpeg_pkg;

  localparam int COEF_W_DEF = 8;
  localparam int RUN_W_DEF  = 6;
  localparam int BLK_N      = 64;
  localparam int ROW_N      = 8;

  localparam int ZZ2NAT [BLK_N] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] zz2nat(input logic [5:0] zz);
    return 6'(ZZ2NAT[zz]);
  endfunction

endpackage

// File: rtl/rle_bank.sv
// One 64-entry coefficient bank: value regs plus a valid mask. Entries whose
// mask bit is clear read as zero, so clearing the mask empties the bank.
module rle_bank
  import jpeg_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [5:0]            wr_addr_i,
  input  logic [COEF_W-1:0]     wr_data_i,
  input  logic                  clr_i,
  input  logic [2:0]            rd_row_i,
  output logic [8*COEF_W-1:0]   rd_data_o
);

  logic [COEF_W-1:0] val_q [BLK_N];
  logic [BLK_N-1:0]  mask_q;

  // Values need no reset: the mask alone decides what reads back.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) val_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else if (clr_i) begin
      mask_q <= '0;
    end else if (wr_en_i) begin
      mask_q[wr_addr_i] <= 1'b1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < ROW_N; c++) begin
      if (mask_q[{rd_row_i, 3'(c)}]) begin
        rd_data_o[COEF_W*c +: COEF_W] = val_q[{rd_row_i, 3'(c)}];
      end
    end
  end

endmodule

// File: rtl/rle_block_decoder.sv
// Expands (run, level, eob) symbols into 8x8 blocks in a ping-pong bank pair
// and drains each block as eight natural-order rows.
module rle_block_decoder
  import jpeg_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int RUN_W  = RUN_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sym_valid_i,
  output logic                sym_ready_o,
  input  logic [RUN_W-1:0]    sym_run_i,
  input  logic [COEF_W-1:0]   sym_level_i,
  input  logic                sym_eob_i,
  output logic                row_valid_o,
  input  logic                row_ready_i,
  output logic [8*COEF_W-1:0] row_data_o,
  output logic [2:0]          row_idx_o,
  output logic [CNT_W-1:0]    blk_cnt_o,
  output logic                err_o
);

  // Both ports use valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid holds its payload until then.

  logic [5:0]       pos_q, pos_d;
  logic             wr_bank_q, rd_bank_q;
  logic [1:0]       full_q, full_d;
  logic [2:0]       row_idx_q;
  logic [CNT_W-1:0] blk_cnt_q;
  logic             err_q;

  logic [6:0] p;
  logic       sym_hs, wr_en, overflow, blk_close, row_acc, row_last;
  logic [8*COEF_W-1:0] bank_rd [2];

  assign sym_ready_o = ~full_q[wr_bank_q];
  assign sym_hs      = sym_valid_i & sym_ready_o;
  // pos never exceeds 63, so p <= 126 and bit 6 alone flags p > 63.
  assign p           = {1'b0, pos_q} + 7'(sym_run_i);
  assign wr_en       = sym_hs & ~sym_eob_i & ~p[6];
  assign overflow    = sym_hs & ~sym_eob_i & p[6];
  assign blk_close   = sym_hs & (sym_eob_i | p[6] | (p == 7'd63));

  assign row_valid_o = full_q[rd_bank_q];
  assign row_acc     = row_valid_o & row_ready_i;
  assign row_last    = row_acc & (row_idx_q == 3'd7);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    rle_bank #(.COEF_W(COEF_W)) u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_en & (wr_bank_q == 1'(b))),
      .wr_addr_i (zz2nat(p[5:0])),
      .wr_data_i (sym_level_i),
      .clr_i     (row_last & (rd_bank_q == 1'(b))),
      .rd_row_i  (row_idx_q),
      .rd_data_o (bank_rd[b])
    );
  end

  assign row_data_o = bank_rd[rd_bank_q];
  assign row_idx_o  = row_idx_q;
  assign blk_cnt_o  = blk_cnt_q;
  assign err_o      = err_q;

  always_comb begin
    pos_d = pos_q;
    if (blk_close)  pos_d = '0;
    else if (wr_en) pos_d = p[5:0] + 6'd1;
  end

  // Close and free always target different banks: a full bank blocks sym_ready.
  always_comb begin
    full_d = full_q;
    if (blk_close) full_d[wr_bank_q] = 1'b1;
    if (row_last)  full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      row_idx_q <= '0;
      blk_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      full_q <= full_d;
      if (blk_close) wr_bank_q <= ~wr_bank_q;
      if (overflow)  err_q <= 1'b1;
      if (row_acc)   row_idx_q <= row_idx_q + 3'd1;
      if (row_last) begin
        rd_bank_q <= ~rd_bank_q;
        if (blk_cnt_q != '1) blk_cnt_q <= blk_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rle_block_decoder.sv
// Directed bench for rle_block_decoder: symbol driver, row scoreboard fed by
// a reference block model, immediate-assertion checks and a summary line.
module tb_rle_block_decoder;

  localparam int W = 67;
  localparam int TB_ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic        clk = 0;
  logic        rst_n = 0;
  logic        sym_valid = 0;
  logic        sym_ready;
  logic [5:0]  sym_run = 0;
  logic [7:0]  sym_level = 0;
  logic        sym_eob = 0;
  logic        row_valid;
  logic        row_ready = 0;
  logic [63:0] row_data;
  logic [2:0]  row_idx;
  logic [15:0] blk_cnt;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int rr_mode = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   m_blk [64];
  int           m_pos = 0;
  logic         m_err = 0;
  logic [15:0]  exp_blk = 0;

  rle_block_decoder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sym_valid_i (sym_valid),
    .sym_ready_o (sym_ready),
    .sym_run_i   (sym_run),
    .sym_level_i (sym_level),
    .sym_eob_i   (sym_eob),
    .row_valid_o (row_valid),
    .row_ready_i (row_ready),
    .row_data_o  (row_data),
    .row_idx_o   (row_idx),
    .blk_cnt_o   (blk_cnt),
    .err_o       (err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       row_ready = 1'b0;
      1:       row_ready = 1'b1;
      default: row_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- checks ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_blk[i] = '0;
    m_pos = 0;
  endtask

  task automatic model_close();
    logic [63:0] row;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row[8*c +: 8] = m_blk[8*r + c];
      exp_q.push_back({3'(r), row});
    end
    model_clear();
  endtask

  task automatic model_sym(input int run, input logic [7:0] lvl, input logic eob);
    int p;
    if (eob) begin
      model_close();
    end else begin
      p = m_pos + run;
      if (p > 63) begin
        m_err = 1'b1;
        model_close();
      end else begin
        m_blk[TB_ZZ[p]] = lvl;
        m_pos = p + 1;
        if (m_pos == 64) model_close();
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_sym(input int run, input logic [7:0] lvl, input logic eob);
    int t = 0;
    sym_valid = 1'b1;
    sym_run   = 6'(run);
    sym_level = lvl;
    sym_eob   = eob;
    while (!sym_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!sym_ready) begin
      chk("sym_timeout", 67'(sym_ready), 67'(1));
    end else begin
      model_sym(run, lvl, eob);
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 67'(exp_q.size()), 67'(0));
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_row_valid"}, 67'(row_valid), 67'(0));
    chk({tag, "_sym_ready"}, 67'(sym_ready), 67'(1));
    chk({tag, "_blk_cnt"},   67'(blk_cnt),   67'(0));
    chk({tag, "_err"},       67'(err),       67'(0));
    exp_q.delete();
    model_clear();
    m_err = 1'b0;
    exp_blk = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_row", {row_idx, row_data}, '0);
      end else begin
        if (exp_q[0][66:64] == 3'd7) exp_blk = exp_blk + 16'd1;
        chk("row", {row_idx, row_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_sym_ready", 67'(sym_ready), 67'(1));
    chk("rst_row_valid", 67'(row_valid), 67'(0));
    chk("rst_row_data",  67'(row_data),  67'(0));
    chk("rst_row_idx",   67'(row_idx),   67'(0));
    chk("rst_blk_cnt",   67'(blk_cnt),   67'(0));
    chk("rst_err",       67'(err),       67'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: eob only -> all-zero block
    rr_mode = 1;
    send_sym(0, 8'd0, 1'b1);
    chk("t1_row_valid_rise", 67'(row_valid), 67'(1));
    wait_drain();
    chk("t1_blk_cnt", 67'(blk_cnt), 67'(exp_blk));
    chk("t1_blk_one", 67'(blk_cnt), 67'(1));
    chk("t1_err",     67'(err),     67'(0));

    // 2: short block with random backpressure
    rr_mode = 2;
    send_sym(0, 8'sd5,  1'b0);
    send_sym(0, -8'sd3, 1'b0);
    send_sym(0, 8'sd7,  1'b0);
    send_sym(0, 8'd0,   1'b1);
    wait_drain();
    chk("t2_blk_cnt", 67'(blk_cnt), 67'(exp_blk));

    // 3: run of 63 closes the block without eob
    rr_mode = 1;
    send_sym(63, 8'sd1, 1'b0);
    chk("t3_row_valid", 67'(row_valid), 67'(1));
    send_sym(0, 8'sd2, 1'b0);
    send_sym(0, 8'd0,  1'b1);
    wait_drain();
    chk("t3_blk_cnt", 67'(blk_cnt), 67'(exp_blk));

    // 4: three dense blocks against a stalled reader
    rr_mode = 0;
    fork
      begin
        for (int b = 0; b < 3; b++)
          for (int k = 1; k <= 64; k++) send_sym(0, 8'(k), 1'b0);
      end
      begin
        repeat (190) @(negedge clk);
        chk("t4_sym_ready_low", 67'(sym_ready), 67'(0));
        chk("t4_row_valid",     67'(row_valid), 67'(1));
        chk("t4_row_hold",      {row_idx, row_data}, exp_q[0]);
        rr_mode = 1;
      end
    join
    wait_drain();
    chk("t4_blk_cnt", 67'(blk_cnt), 67'(exp_blk));

    // 5: overflow drops the symbol and sets sticky err
    send_sym(40, 8'sd9, 1'b0);
    send_sym(30, 8'sd4, 1'b0);
    chk("t5_err_set", 67'(err), 67'(m_err));
    wait_drain();
    send_sym(0, 8'd0, 1'b1);
    wait_drain();
    chk("t5_err_sticky", 67'(err), 67'(1));
    chk("t5_blk_cnt",    67'(blk_cnt), 67'(exp_blk));

    // 6: async reset mid-block, then mid-drain
    send_sym(0, 8'sd1, 1'b0);
    send_sym(0, 8'sd2, 1'b0);
    @(negedge clk);
    pulse_reset("t6a");
    rr_mode = 2;
    send_sym(5, 8'sd3, 1'b0);
    send_sym(0, 8'd0,  1'b1);
    begin
      int t = 0;
      while (row_idx != 3'd3 && t < 500) begin
        @(negedge clk);
        t++;
      end
      chk("t6_reach_row3", 67'(row_idx), 67'(3));
    end
    pulse_reset("t6b");
    rr_mode = 1;
    send_sym(0, 8'sd4, 1'b0);
    send_sym(0, 8'd0,  1'b1);
    wait_drain();
    chk("t6_blk_cnt", 67'(blk_cnt), 67'(1));
    chk("t6_err",     67'(err),     67'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
